// File: rtl/ether_tx_sched_if.sv
// Bundle between the packet sources, the transmit scheduler and the MAC send path.
// The scheduler uses the slave modport; whoever models the sources and the MAC uses master.
interface ether_tx_sched_if #(
  parameter int unsigned NREQ = 3
) ();
  logic [NREQ-1:0]    i_req;
  logic [NREQ*10-1:0] i_len;
  logic [NREQ*16-1:0] i_data;
  logic [NREQ-1:0]    o_grant;
  logic [NREQ-1:0]    o_done;
  logic               o_err;
  logic [9:0]         o_rd_addr;
  logic               o_send_irq;
  logic [9:0]         o_length;
  logic [15:0]        o_mac_data;
  logic [9:0]         i_mac_addr;
  logic               i_mac_idle;

  modport master (
    output i_req, i_len, i_data, i_mac_addr, i_mac_idle,
    input  o_grant, o_done, o_err, o_rd_addr, o_send_irq, o_length, o_mac_data
  );

  modport slave (
    input  i_req, i_len, i_data, i_mac_addr, i_mac_idle,
    output o_grant, o_done, o_err, o_rd_addr, o_send_irq, o_length, o_mac_data
  );
endinterface

// File: rtl/ether_tx_sched.sv
// Shares the single MAC send path among NREQ packet sources: fixed priority for source 0,
// round-robin among the rest, inter-packet gap and a watchdog against a hung MAC.
module ether_tx_sched #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned GAP_CYC  = 24,
  parameter int unsigned IRQ_HOLD = 4,
  parameter int unsigned TMO_CYC  = 4096
) (
  input logic             i_clk,
  input logic             i_rst,
  ether_tx_sched_if.slave bus
);

  localparam int unsigned IdxW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TmoLast = 16'(TMO_CYC - 1);
  localparam logic [15:0] GapLast = 16'(GAP_CYC - 1);
  localparam logic [15:0] IrqHold = 16'(IRQ_HOLD);

  typedef enum logic [2:0] {StIdle, StStart, StBusy, StDone, StGap} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic            irq_q, irq_d;
  logic [9:0]      len_q, len_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     mac_data_q, mac_data_d;

  logic [9:0]      len_arr  [NREQ];
  logic [15:0]     data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign len_arr[g]  = bus.i_len[10*g +: 10];
    assign data_arr[g] = bus.i_data[16*g +: 16];
  end

  // Winner: source 0 always; otherwise first requester scanning 1..NREQ-1 from rr_q.
  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [IdxW-1:0] rr_next;
  logic [9:0]      win_len;
  int              cand_int;
  logic [IdxW-1:0] cand;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand_int  = 0;
    cand      = '0;
    if (bus.i_req[0]) begin
      win_valid = 1'b1;
    end else begin
      for (int off = 0; off < int'(NREQ) - 1; off++) begin
        cand_int = int'(rr_q) + off;
        if (cand_int >= int'(NREQ)) cand_int = cand_int - (int'(NREQ) - 1);
        cand = IdxW'(cand_int);
        if (!win_valid && bus.i_req[cand]) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    win_len             = len_arr[win_idx];
    rr_next = (int'(win_idx) + 1 >= int'(NREQ)) ? IdxW'(1) : win_idx + IdxW'(1);
  end

  logic abort;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    len_d   = len_q;
    cnt_d   = cnt_q + 16'd1;
    done_d  = '0;
    err_d   = 1'b0;
    irq_d   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (win_valid && bus.i_mac_idle) begin
          grant_d = win_onehot;
          len_d   = (win_len == 10'd0) ? 10'd1 : win_len;
          if (win_idx != '0) rr_d = rr_next;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == IrqHold) begin
          state_d = StBusy;
          cnt_d   = '0;
        end else begin
          irq_d = 1'b1;
        end
      end
      StBusy: begin
        if (!bus.i_mac_idle) begin
          state_d = StDone;
          cnt_d   = '0;
        end else if (cnt_q == TmoLast) begin
          abort = 1'b1;
        end
      end
      StDone: begin
        if (bus.i_mac_idle) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = StGap;
          cnt_d   = '0;
        end else if (cnt_q == TmoLast) begin
          abort = 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Watchdog abort releases the owner but keeps the length latch.
    if (abort) begin
      err_d   = 1'b1;
      done_d  = grant_q;
      grant_d = '0;
      state_d = StGap;
      cnt_d   = '0;
    end
  end

  always_comb begin
    mac_data_d = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (grant_q[k]) mac_data_d = mac_data_d | data_arr[k];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      rr_q       <= IdxW'(1);
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      mac_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      mac_data_q <= mac_data_d;
    end
  end

  assign bus.o_grant    = grant_q;
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_send_irq = irq_q;
  assign bus.o_length   = len_q;
  assign bus.o_mac_data = mac_data_q;
  assign bus.o_rd_addr  = bus.i_mac_addr;

endmodule
